// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared 7-segment definitions for the hex counter/scan display.
//             SEG_OFF   - glyph with every segment dark (active-high sense)
//             hex_to_seg - nibble to {g,f,e,d,c,b,a} glyph, full 0-F set
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] w_glyph;
      case (nibble)
         4'h0:    w_glyph = 7'h3f;
         4'h1:    w_glyph = 7'h06;
         4'h2:    w_glyph = 7'h5b;
         4'h3:    w_glyph = 7'h4f;
         4'h4:    w_glyph = 7'h66;
         4'h5:    w_glyph = 7'h6d;
         4'h6:    w_glyph = 7'h7d;
         4'h7:    w_glyph = 7'h07;
         4'h8:    w_glyph = 7'h7f;
         4'h9:    w_glyph = 7'h6f;
         4'ha:    w_glyph = 7'h77;
         4'hb:    w_glyph = 7'h7c;
         4'hc:    w_glyph = 7'h39;
         4'hd:    w_glyph = 7'h5e;
         4'he:    w_glyph = 7'h79;
         default: w_glyph = 7'h71;
      endcase
      return w_glyph;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Synchronises and debounces one raw push-key (pressed = 0) and
//             emits a single-clock pulse on each accepted press.
//  Ports    : clk         system clock
//             rst_n       asynchronous active-low reset
//             key_raw     raw asynchronous key level
//             press_pulse 1-clk pulse on accepted 1->0 transition
//             key_level   accepted (debounced) key level, 1 = released
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
   parameter int DEB_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic press_pulse,
   output logic key_level
);

   localparam int                 c_CNT_W  = $clog2(DEB_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(DEB_CYCLES - 1);

   logic [1:0]         r_sync;
   logic               r_sync_prev;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_level;
   logic               r_pulse;

   logic w_synced;
   logic w_changed;
   logic w_stable;

   assign w_synced  = r_sync[1];
   assign w_changed = w_synced ^ r_sync_prev;
   // r_cnt holds how many earlier consecutive cycles carried the current
   // synced level, so this cycle is sample number DEB_CYCLES when it equals
   // DEB_CYCLES-1 and no change is seen now.
   assign w_stable  = !w_changed && (r_cnt >= c_STABLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync      <= 2'b11;
         r_sync_prev <= 1'b1;
         r_cnt       <= '0;
         r_level     <= 1'b1;
         r_pulse     <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], key_raw};
         r_sync_prev <= w_synced;
         if (w_changed) begin
            r_cnt <= c_CNT_W'(1);
         end else if (r_cnt < c_STABLE) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
         // Pulse only on an accepted released->pressed change; r_level
         // updates on the same edge so the pulse cannot repeat.
         r_pulse <= w_stable && r_level && !w_synced;
         if (w_stable) begin
            r_level <= w_synced;
         end
      end
   end

   assign press_pulse = r_pulse;
   assign key_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/seg_hex_counter_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_hex_counter_scan
//  Purpose  : Key-driven hex up/down counter of DIGITS nibbles, scanned onto
//             a time-multiplexed common-segment 7-segment display.
//  Ports    : clk      system clock
//             rst_n    asynchronous active-low reset
//             key_inc  raw increment key, pressed = 0
//             key_dec  raw decrement key, pressed = 0
//             clr      synchronous clear of the count, active-high
//             seg_led  {dp,g,f,e,d,c,b,a}, dp always off
//             dig_sel  one-hot digit enable, bit 0 = least significant nibble
//             count_o  current count value
//  Revision : 1.0  initial release
// ============================================================================
module seg_hex_counter_scan
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DEB_CYCLES  = 65535,
   parameter int SCAN_DIV    = 1000,
   parameter int SEG_ACT_LOW = 0,
   parameter int DIG_ACT_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_inc,
   input  logic                  key_dec,
   input  logic                  clr,
   output logic [7:0]            seg_led,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   count_o
);

   localparam int c_CW    = 4 * DIGITS;
   localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_DIV_W = $clog2(SCAN_DIV);

   logic w_inc_pulse;
   logic w_dec_pulse;
   logic w_unused_levels_inc;
   logic w_unused_levels_dec;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_inc),
      .press_pulse (w_inc_pulse),
      .key_level   (w_unused_levels_inc)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_dec),
      .press_pulse (w_dec_pulse),
      .key_level   (w_unused_levels_dec)
   );

   // ------------------------------------------------------------------------
   // Counter: modulo 16**DIGITS falls out of the register width.
   // ------------------------------------------------------------------------
   logic [c_CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (w_inc_pulse && w_dec_pulse) begin
         r_count <= r_count;
      end else if (w_inc_pulse) begin
         r_count <= r_count + c_CW'(1);
      end else if (w_dec_pulse) begin
         r_count <= r_count - c_CW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Scan divider and digit index. r_idx names the digit that is loaded into
   // the output registers at the coming tick, so the first tick after reset
   // lights digit 0.
   // ------------------------------------------------------------------------
   logic [c_DIV_W-1:0] r_div;
   logic [c_IDX_W-1:0] r_idx;
   logic               w_tick;

   assign w_tick = (r_div == c_DIV_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + c_DIV_W'(1);
         if (w_tick) begin
            r_idx <= (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + c_IDX_W'(1);
         end
      end
   end

   // Nibble select and one-hot decode of the slot being loaded.
   logic [3:0]        w_nibble;
   logic [DIGITS-1:0] w_onehot;

   always_comb begin
      w_nibble = 4'h0;
      w_onehot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == c_IDX_W'(i)) begin
            w_nibble    = r_count[i*4 +: 4];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output registers, held between ticks; kept in active-high sense and
   // inverted at the pins when the board needs it.
   // ------------------------------------------------------------------------
   logic [7:0]        r_seg;
   logic [DIGITS-1:0] r_dig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= {1'b0, SEG_OFF};
         r_dig <= '0;
      end else if (w_tick) begin
         r_seg <= {1'b0, hex_to_seg(w_nibble)};
         r_dig <= w_onehot;
      end
   end

   assign seg_led = (SEG_ACT_LOW != 0) ? ~r_seg : r_seg;
   assign dig_sel = (DIG_ACT_LOW != 0) ? ~r_dig : r_dig;
   assign count_o = r_count;

endmodule
`default_nettype wire
